// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
// Definitions shared by the pipeline stage register and its storage slot.
//   CTRL_RW / CTRL_M2R : bit positions of RegWrite and M2Reg in the control
//                        vector when the stage is used as the M->W latch
//   DEF_*_W            : default payload, target-register and control widths
//   stageState_t       : occupancy of the stage (nothing / main / main+skid)
// ----------------------------------------------------------------------------
package pipe_pkg;

    localparam int CTRL_RW  = 0;
    localparam int CTRL_M2R = 1;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_TGT_W  = 5;
    localparam int DEF_CTRL_W = 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stageState_t;

endpackage

// File: rtl/pipe_slot.sv
// ----------------------------------------------------------------------------
// pipe_slot
// One storage entry of a pipeline stage: valid flag, control bits, target
// register index and payload.
//   clk, clrn          : rising-edge clock, synchronous active-low reset
//   load               : capture dCtrl/dTgt/dData and mark the entry valid
//   clear              : invalidate the entry and zero its control and target
//                        (payload is left alone); load wins over clear
//   dCtrl, dTgt, dData : values captured on load
//   qValid, qCtrl,
//   qTgt, qData        : registered contents of the entry
// ----------------------------------------------------------------------------
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int TGT_W  = DEF_TGT_W,
    parameter int CTRL_W = DEF_CTRL_W
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] dCtrl,
    input  logic [TGT_W-1:0]  dTgt,
    input  logic [DATA_W-1:0] dData,
    output logic              qValid,
    output logic [CTRL_W-1:0] qCtrl,
    output logic [TGT_W-1:0]  qTgt,
    output logic [DATA_W-1:0] qData
);

    // The entry register. Control and target are zeroed whenever the entry
    // goes invalid, so an empty slot can never present a live RegWrite or
    // M2Reg downstream. The payload is only cleared by reset; leaving it
    // alone on drain saves needless toggling of the wide data bus.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            qValid <= 1'b0;
            qCtrl  <= '0;
            qTgt   <= '0;
            qData  <= '0;
        end else if (load) begin
            qValid <= 1'b1;
            qCtrl  <= dCtrl;
            qTgt   <= dTgt;
            qData  <= dData;
        end else if (clear) begin
            qValid <= 1'b0;
            qCtrl  <= '0;
            qTgt   <= '0;
        end
    end

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// ----------------------------------------------------------------------------
// pipe_stage_skid_reg
// Parametrised pipeline stage register with valid/ready handshake, flush and
// an optional skid entry that breaks the out_ready -> in_ready path.
//   clk, clrn                  : rising-edge clock, synchronous active-low reset
//   flush                      : discard every held entry and any entry
//                                offered this cycle
//   in_valid / in_ready        : upstream handshake
//   in_ctrl, in_tgt, in_data   : upstream entry
//   out_valid / out_ready      : downstream handshake
//   out_ctrl, out_tgt          : registered, zero whenever out_valid is 0
//   out_data                   : payload, holds its last value when invalid
// SKID=1 registers in_ready (it is simply "skid entry empty"); SKID=0 is a
// single entry with in_ready = out_ready | ~out_valid.
// ----------------------------------------------------------------------------
module pipe_stage_skid_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int TGT_W  = DEF_TGT_W,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [TGT_W-1:0]  in_tgt,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [TGT_W-1:0]  out_tgt,
    output logic [DATA_W-1:0] out_data
);

    logic              inXfer;
    logic              outXfer;
    logic              mainLoad;
    logic              mainClear;
    logic [CTRL_W-1:0] mainDCtrl;
    logic [TGT_W-1:0]  mainDTgt;
    logic [DATA_W-1:0] mainDData;

    assign inXfer  = in_valid & in_ready;
    assign outXfer = out_valid & out_ready;

    // The main entry drives the stage outputs directly, so out_ctrl and
    // out_tgt are flop outputs rather than a gate after the register.
    pipe_slot #(
        .DATA_W(DATA_W),
        .TGT_W (TGT_W),
        .CTRL_W(CTRL_W)
    ) mainSlot (
        .clk   (clk),
        .clrn  (clrn),
        .load  (mainLoad),
        .clear (mainClear),
        .dCtrl (mainDCtrl),
        .dTgt  (mainDTgt),
        .dData (mainDData),
        .qValid(out_valid),
        .qCtrl (out_ctrl),
        .qTgt  (out_tgt),
        .qData (out_data)
    );

    generate
        if (SKID != 0) begin : genSkid

            stageState_t       state;
            stageState_t       stateNext;
            logic              skidLoad;
            logic              skidClear;
            logic              mainFromSkid;
            logic              skidValid;
            logic [CTRL_W-1:0] skidCtrl;
            logic [TGT_W-1:0]  skidTgt;
            logic [DATA_W-1:0] skidData;

            // Second entry that catches the one beat which arrives while
            // the downstream is stalled; in_ready only looks at this flop.
            pipe_slot #(
                .DATA_W(DATA_W),
                .TGT_W (TGT_W),
                .CTRL_W(CTRL_W)
            ) skidSlot (
                .clk   (clk),
                .clrn  (clrn),
                .load  (skidLoad),
                .clear (skidClear),
                .dCtrl (in_ctrl),
                .dTgt  (in_tgt),
                .dData (in_data),
                .qValid(skidValid),
                .qCtrl (skidCtrl),
                .qTgt  (skidTgt),
                .qData (skidData)
            );

            assign in_ready = ~skidValid;

            // Occupancy state register; reset and flush both return to EMPTY.
            always_ff @(posedge clk) begin
                if (!clrn) begin
                    state <= ST_EMPTY;
                end else begin
                    state <= stateNext;
                end
            end

            // Occupancy transitions. Flush empties both entries and ignores
            // whatever is offered upstream. When the main entry drains while
            // the skid entry is full, the skid entry moves forward so FIFO
            // order is kept.
            always_comb begin
                stateNext    = state;
                mainLoad     = 1'b0;
                mainClear    = 1'b0;
                mainFromSkid = 1'b0;
                skidLoad     = 1'b0;
                skidClear    = 1'b0;
                if (flush) begin
                    stateNext = ST_EMPTY;
                    mainClear = 1'b1;
                    skidClear = 1'b1;
                end else begin
                    case (state)
                        ST_EMPTY: begin
                            if (inXfer) begin
                                mainLoad  = 1'b1;
                                stateNext = ST_ONE;
                            end
                        end
                        ST_ONE: begin
                            if (inXfer && outXfer) begin
                                mainLoad = 1'b1;
                            end else if (inXfer) begin
                                skidLoad  = 1'b1;
                                stateNext = ST_FULL;
                            end else if (outXfer) begin
                                mainClear = 1'b1;
                                stateNext = ST_EMPTY;
                            end
                        end
                        ST_FULL: begin
                            if (outXfer) begin
                                mainLoad     = 1'b1;
                                mainFromSkid = 1'b1;
                                skidClear    = 1'b1;
                                stateNext    = ST_ONE;
                            end
                        end
                        default: begin
                            stateNext = ST_EMPTY;
                            mainClear = 1'b1;
                            skidClear = 1'b1;
                        end
                    endcase
                end
            end

            // Source for the main entry: the skid entry when it is moving
            // forward, otherwise the upstream inputs.
            always_comb begin
                mainDCtrl = in_ctrl;
                mainDTgt  = in_tgt;
                mainDData = in_data;
                if (mainFromSkid) begin
                    mainDCtrl = skidCtrl;
                    mainDTgt  = skidTgt;
                    mainDData = skidData;
                end
            end

        end else begin : genNoSkid

            assign in_ready = out_ready | ~out_valid;

            // Single entry: a new beat overwrites the one leaving, a drain
            // with nothing arriving empties the entry, flush kills it.
            always_comb begin
                mainLoad  = inXfer & ~flush;
                mainClear = flush | outXfer;
                mainDCtrl = in_ctrl;
                mainDTgt  = in_tgt;
                mainDData = in_data;
            end

        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// ----------------------------------------------------------------------------
// tb_pipe_stage_skid_reg
// Drives one SKID=1 and one SKID=0 instance of pipe_stage_skid_reg and checks
// their outputs against per-instance scoreboard queues of expected entries.
// ----------------------------------------------------------------------------
module tb_pipe_stage_skid_reg;

    logic        clk;
    logic        clrn;

    logic        sFlush, sInValid, sInReady, sOutValid, sOutReady;
    logic [1:0]  sInCtrl, sOutCtrl;
    logic [4:0]  sInTgt, sOutTgt;
    logic [31:0] sInData, sOutData;

    logic        nFlush, nInValid, nInReady, nOutValid, nOutReady;
    logic [1:0]  nInCtrl, nOutCtrl;
    logic [4:0]  nInTgt, nOutTgt;
    logic [31:0] nInData, nOutData;

    logic [38:0] sbSkid[$];
    logic [38:0] sbNoSkid[$];

    int compareCount = 0;
    int failCount    = 0;

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    pipe_stage_skid_reg #(
        .DATA_W(32), .TGT_W(5), .CTRL_W(2), .SKID(1)
    ) dutSkid (
        .clk      (clk),
        .clrn     (clrn),
        .flush    (sFlush),
        .in_valid (sInValid),
        .in_ready (sInReady),
        .in_ctrl  (sInCtrl),
        .in_tgt   (sInTgt),
        .in_data  (sInData),
        .out_valid(sOutValid),
        .out_ready(sOutReady),
        .out_ctrl (sOutCtrl),
        .out_tgt  (sOutTgt),
        .out_data (sOutData)
    );

    pipe_stage_skid_reg #(
        .DATA_W(32), .TGT_W(5), .CTRL_W(2), .SKID(0)
    ) dutNoSkid (
        .clk      (clk),
        .clrn     (clrn),
        .flush    (nFlush),
        .in_valid (nInValid),
        .in_ready (nInReady),
        .in_ctrl  (nInCtrl),
        .in_tgt   (nInTgt),
        .in_data  (nInData),
        .out_valid(nOutValid),
        .out_ready(nOutReady),
        .out_ctrl (nOutCtrl),
        .out_tgt  (nOutTgt),
        .out_data (nOutData)
    );

    // One comparison of an observed value against the bench's expectation.
    task automatic checkOutput(input string tag, input logic [38:0] observed,
                               input logic [38:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h required %h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs on the chosen instance after the falling
    // edge, then settles and books the coming clock edge: an output transfer
    // pops and checks the oldest expected entry, an input transfer pushes a
    // new one, and a flush throws away everything still expected.
    task automatic applyStimulus(input bit useSkid, input logic v, input logic [1:0] c,
                                 input logic [4:0] t, input logic [31:0] d,
                                 input logic oR, input logic fl);
        logic        outV;
        logic        inR;
        logic [38:0] observed;
        logic [38:0] expected;
        int          qSize;
        @(negedge clk);
        if (useSkid) begin
            sInValid = v; sInCtrl = c; sInTgt = t; sInData = d; sOutReady = oR; sFlush = fl;
        end else begin
            nInValid = v; nInCtrl = c; nInTgt = t; nInData = d; nOutReady = oR; nFlush = fl;
        end
        #1;
        if (useSkid) begin
            outV = sOutValid; inR = sInReady; observed = {sOutCtrl, sOutTgt, sOutData};
            qSize = sbSkid.size();
        end else begin
            outV = nOutValid; inR = nInReady; observed = {nOutCtrl, nOutTgt, nOutData};
            qSize = sbNoSkid.size();
        end
        if (outV && oR) begin
            compareCount++;
            assert (qSize != 0) else begin
                failCount++;
                $error("[TB] FAIL sb_extra: observed %h required no entry", observed);
            end
            if (qSize != 0) begin
                if (useSkid) expected = sbSkid.pop_front();
                else         expected = sbNoSkid.pop_front();
                checkOutput(useSkid ? "sb_skid" : "sb_noskid", observed, expected);
            end
        end
        if (fl) begin
            if (useSkid) sbSkid.delete();
            else         sbNoSkid.delete();
        end else if (v && inR) begin
            if (useSkid) sbSkid.push_back({c, t, d});
            else         sbNoSkid.push_back({c, t, d});
        end
    endtask

    initial begin
        logic        v;
        logic        oR;
        logic [1:0]  c;
        logic [4:0]  t;
        logic [31:0] d;

        clrn = 1'b0;
        sFlush = 1'b0; sInValid = 1'b1; sInCtrl = 2'b11; sInTgt = 5'd7; sInData = 32'hA5A5_0001;
        sOutReady = 1'b1;
        nFlush = 1'b0; nInValid = 1'b1; nInCtrl = 2'b11; nInTgt = 5'd7; nInData = 32'hA5A5_0002;
        nOutReady = 1'b1;

        // Reset held for three edges while upstream claims valid.
        $display("[TB] reset");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_s_valid", {38'd0, sOutValid}, 39'd0);
        checkOutput("rst_s_ctrl",  {37'd0, sOutCtrl}, 39'd0);
        checkOutput("rst_s_tgt",   {34'd0, sOutTgt}, 39'd0);
        checkOutput("rst_s_data",  {7'd0, sOutData}, 39'd0);
        checkOutput("rst_n_valid", {38'd0, nOutValid}, 39'd0);
        checkOutput("rst_n_data",  {7'd0, nOutData}, 39'd0);
        @(negedge clk);
        clrn = 1'b1; sInValid = 1'b0; nInValid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_s_ready", {38'd0, sInReady}, 39'd1);
        checkOutput("rst_n_ready", {38'd0, nInReady}, 39'd1);
        checkOutput("rst_s_valid2", {38'd0, sOutValid}, 39'd0);

        // Back-to-back stream with downstream always ready.
        $display("[TB] stream");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 1'b1, 2'b01, 5'(i + 1), 32'(i + 1), 1'b1, 1'b0);
            checkOutput("stream_ready", {38'd0, sInReady}, 39'd1);
            if (i > 0) checkOutput("stream_nogap", {38'd0, sOutValid}, 39'd1);
        end
        applyStimulus(1, 1'b0, 2'b00, 5'd0, 32'd0, 1'b1, 1'b0);
        checkOutput("stream_last", {38'd0, sOutValid}, 39'd1);
        applyStimulus(1, 1'b0, 2'b00, 5'd0, 32'd0, 1'b1, 1'b0);
        checkOutput("stream_drained", {38'd0, sOutValid}, 39'd0);
        checkOutput("stream_ctrl0", {37'd0, sOutCtrl}, 39'd0);

        // Backpressure: A held on output, B in skid, C waits upstream.
        $display("[TB] backpressure");
        applyStimulus(1, 1'b1, 2'b01, 5'd1, 32'h0000_00A0, 1'b0, 1'b0);
        applyStimulus(1, 1'b1, 2'b10, 5'd2, 32'h0000_00B0, 1'b0, 1'b0);
        applyStimulus(1, 1'b1, 2'b11, 5'd3, 32'h0000_00C0, 1'b0, 1'b0);
        checkOutput("bp_full_ready", {38'd0, sInReady}, 39'd0);
        checkOutput("bp_hold_valid", {38'd0, sOutValid}, 39'd1);
        checkOutput("bp_hold_data", {7'd0, sOutData}, 39'h0A0);
        applyStimulus(1, 1'b1, 2'b11, 5'd3, 32'h0000_00C0, 1'b1, 1'b0);
        checkOutput("bp_drain_ready", {38'd0, sInReady}, 39'd0);
        applyStimulus(1, 1'b1, 2'b11, 5'd3, 32'h0000_00C0, 1'b1, 1'b0);
        checkOutput("bp_b_valid", {38'd0, sOutValid}, 39'd1);
        checkOutput("bp_b_ready", {38'd0, sInReady}, 39'd1);
        applyStimulus(1, 1'b0, 2'b00, 5'd0, 32'd0, 1'b1, 1'b0);
        checkOutput("bp_c_valid", {38'd0, sOutValid}, 39'd1);
        applyStimulus(1, 1'b0, 2'b00, 5'd0, 32'd0, 1'b1, 1'b0);
        checkOutput("bp_empty", {38'd0, sOutValid}, 39'd0);

        // Flush while FULL with a new entry offered.
        $display("[TB] flush");
        applyStimulus(1, 1'b1, 2'b01, 5'd4, 32'h0000_00D0, 1'b0, 1'b0);
        applyStimulus(1, 1'b1, 2'b11, 5'd5, 32'h0000_00E0, 1'b0, 1'b0);
        applyStimulus(1, 1'b1, 2'b11, 5'd6, 32'h0000_00F0, 1'b0, 1'b1);
        applyStimulus(1, 1'b0, 2'b00, 5'd0, 32'd0, 1'b1, 1'b0);
        checkOutput("flush_valid", {38'd0, sOutValid}, 39'd0);
        checkOutput("flush_ctrl", {37'd0, sOutCtrl}, 39'd0);
        checkOutput("flush_tgt", {34'd0, sOutTgt}, 39'd0);
        checkOutput("flush_ready", {38'd0, sInReady}, 39'd1);
        applyStimulus(1, 1'b1, 2'b01, 5'd9, 32'h0000_0123, 1'b1, 1'b0);
        applyStimulus(1, 1'b0, 2'b00, 5'd0, 32'd0, 1'b1, 1'b0);
        // Flush in ONE: the held entry leaves downstream, the offered one dies.
        applyStimulus(1, 1'b1, 2'b01, 5'd10, 32'h0000_0456, 1'b0, 1'b0);
        applyStimulus(1, 1'b1, 2'b11, 5'd11, 32'h0000_0789, 1'b1, 1'b1);
        applyStimulus(1, 1'b0, 2'b00, 5'd0, 32'd0, 1'b1, 1'b0);
        checkOutput("flush1_valid", {38'd0, sOutValid}, 39'd0);
        checkOutput("flush1_data_held", {7'd0, sOutData}, 39'h456);

        // Bubble with live-looking control/target on the inputs.
        $display("[TB] bubble");
        applyStimulus(1, 1'b0, 2'b11, 5'd31, 32'hDEAD_BEEF, 1'b1, 1'b0);
        applyStimulus(1, 1'b0, 2'b11, 5'd31, 32'hDEAD_BEEF, 1'b1, 1'b0);
        checkOutput("bubble_valid", {38'd0, sOutValid}, 39'd0);
        checkOutput("bubble_ctrl", {37'd0, sOutCtrl}, 39'd0);
        checkOutput("bubble_tgt", {34'd0, sOutTgt}, 39'd0);
        checkOutput("skid_sb_empty", 39'(sbSkid.size()), 39'd0);

        // SKID=0 instance: random handshakes, X payload on bubbles.
        $display("[TB] random single-entry");
        for (int i = 0; i < 1000; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            oR = ($urandom_range(0, 3) != 0);
            if (v) begin
                c = 2'($urandom); t = 5'($urandom); d = $urandom;
            end else begin
                c = 'x; t = 'x; d = 'x;
            end
            applyStimulus(0, v, c, t, d, oR, 1'b0);
            checkOutput("ns_ready", {38'd0, nInReady}, {38'd0, oR | ~nOutValid});
            if (!nOutValid) checkOutput("ns_bubble_ctrl", {32'd0, nOutCtrl, nOutTgt}, 39'd0);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1'b0, 2'b00, 5'd0, 32'd0, 1'b1, 1'b0);
        end
        checkOutput("ns_drained", {38'd0, nOutValid}, 39'd0);
        checkOutput("ns_sb_empty", 39'(sbNoSkid.size()), 39'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
